// File: rtl/uart_case_echo.sv
// UART echo with case transform: receives bytes on rx, applies the mode-selected
// case mapping, buffers them in a FIFO and retransmits them on tx (full duplex).
// Optional build macro UART_CASE_ECHO_PARITY_EN adds an even-parity bit on both RX and TX.
module uart_case_echo #(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE       = 115_200,
    parameter int unsigned FIFO_AW         = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    output logic             tx,
    input  logic [1:0]       mode,
    output logic [FIFO_AW:0] fifo_count,
    output logic             overflow,
    output logic             frame_err,
    output logic             tx_busy
);

    localparam int unsigned DIV       = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CW        = $clog2(DIV) + 1;
    localparam int unsigned DEPTH     = 2 ** FIFO_AW;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    // Case mapping applied at FIFO-write time.
    function automatic logic [7:0] case_xform(input logic [7:0] b, input logic [1:0] m);
        logic is_lower;
        logic is_upper;
        is_lower = (b >= 8'h61) && (b <= 8'h7A);
        is_upper = (b >= 8'h41) && (b <= 8'h5A);
        case (m)
            2'b01:   case_xform = is_lower ? b - 8'h20 : b;
            2'b10:   case_xform = is_upper ? b + 8'h20 : b;
            2'b11:   case_xform = is_lower ? b - 8'h20 : (is_upper ? b + 8'h20 : b);
            default: case_xform = b;
        endcase
    endfunction

    // rx synchroniser plus one delayed copy for falling-edge detection.
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_done_q, rx_done_d;
    logic          frame_err_q, frame_err_d;
`ifdef UART_CASE_ECHO_PARITY_EN
    logic          rx_perr_q, rx_perr_d;
`endif

    // RX next state: sample mid-bit, counting from the detected start edge.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_CASE_ECHO_PARITY_EN
        rx_perr_d   = rx_perr_q;
`endif
        case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_CASE_ECHO_PARITY_EN
                        rx_state_d = RxParity;
`else
                        rx_state_d = RxStop;
`endif
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
`ifdef UART_CASE_ECHO_PARITY_EN
            RxParity: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = rx_sync_q ^ (^rx_shift_q);
                    rx_state_d = RxStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
`endif
            RxStop: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
`ifdef UART_CASE_ECHO_PARITY_EN
                    if (rx_sync_q && !rx_perr_q) begin
`else
                    if (rx_sync_q) begin
`endif
                        rx_done_d = 1'b1;
                        rx_byte_d = rx_shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_CASE_ECHO_PARITY_EN
            rx_perr_q   <= 1'b0;
`endif
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_CASE_ECHO_PARITY_EN
            rx_perr_q   <= rx_perr_d;
`endif
        end
    end

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               fifo_empty, fifo_full, fifo_wr, tx_pop;
    logic [7:0]         wr_byte;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    // A full FIFO still accepts when the TX pops in the same cycle.
    assign fifo_wr    = rx_done_q && (!fifo_full || tx_pop);
    assign wr_byte    = case_xform(rx_byte_q, mode);

    // FIFO pointer, occupancy and sticky overflow next state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (rx_done_q && fifo_full && !tx_pop);
        if (fifo_wr) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (tx_pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        if (fifo_wr && !tx_pop)      count_d = count_q + (FIFO_AW + 1)'(1);
        else if (!fifo_wr && tx_pop) count_d = count_q - (FIFO_AW + 1)'(1);
    end

    // FIFO state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= wr_byte;
    end

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
`ifdef UART_CASE_ECHO_PARITY_EN
    logic          tx_par_q, tx_par_d;
`endif

    // TX next state; a pop from Idle or end of Stop loads the next byte.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
`ifdef UART_CASE_ECHO_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_pop     = 1'b0;
        case (tx_state_q)
            TxIdle: tx_pop = !fifo_empty;
            TxStart: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxData: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_CASE_ECHO_PARITY_EN
                        tx_state_d = TxParity;
`else
                        tx_state_d = TxStop;
`endif
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
`ifdef UART_CASE_ECHO_PARITY_EN
            TxParity: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxStop;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
`endif
            TxStop: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                    tx_pop     = !fifo_empty;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        if (tx_pop) begin
            tx_state_d = TxStart;
            tx_cnt_d   = '0;
            tx_shift_d = mem_q[rd_ptr_q];
`ifdef UART_CASE_ECHO_PARITY_EN
            tx_par_d   = ^mem_q[rd_ptr_q];
`endif
        end
    end

    // TX state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
`ifdef UART_CASE_ECHO_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
`ifdef UART_CASE_ECHO_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // Line driver decoded from TX state so reset forces idle-high at once.
    always_comb begin
        tx = 1'b1;
        case (tx_state_q)
            TxStart: tx = 1'b0;
            TxData:  tx = tx_shift_q[0];
`ifdef UART_CASE_ECHO_PARITY_EN
            TxParity: tx = tx_par_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy    = (tx_state_q != TxIdle);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule
